mem_burst_ctrl: RTL

//  Upstream master for the single-port `memory` block (valid/ready, addr, wr_rd, wdata, rdata).

---
 rtl/mem_burst_ctrl_pkg.sv | 25 ++
 rtl/mem_burst_ctrl_if.sv | 26 ++
 rtl/mem_burst_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the memory burst controller, the memory block and benches.
//   DEPTH / WIDTH  default memory geometry (DEPTH must be a power of 2)
//   addr_t / data_t / len_t  bus payload types at the default geometry
//   burst_state_e  burst sequencer states
package mem_pkg;

  localparam int unsigned DEPTH      = 64;
  localparam int unsigned WIDTH      = 16;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [WIDTH-1:0]      data_t;
  typedef logic [LEN_WIDTH-1:0]  len_t;

  typedef enum logic [2:0] {
    IDLE,
    WFETCH,
    WREQ,
    RREQ,
    RHOLD,
    FIN
  } burst_state_e;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Single-port memory bus (valid/ready handshake, one word per transfer).
//   master: addr, wr_rd (1=write), wdata, valid out; rdata, ready in
//   slave : the mirror image, implemented by the memory
interface mem_burst_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int unsigned WIDTH      = mem_pkg::WIDTH
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_rd;
  logic [WIDTH-1:0]      wdata;
  logic                  valid;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (
    output addr, wr_rd, wdata, valid,
    input  rdata, ready
  );

  modport slave (
    input  addr, wr_rd, wdata, valid,
    output rdata, ready
  );

endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of the single-port memory: turns one command
// (start address, word count, direction) into a series of single-word memory
// handshakes, pulling write words from a stream or pushing read words to one.
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready, cmd_wr, cmd_addr, cmd_len   burst command
//   wr_data/valid/ready      write word stream (into the controller)
//   rd_data/valid/ready      read word stream (out of the controller)
//   busy, done               burst in progress, one-cycle completion pulse
//   mem                      memory bus, master side
module mem_burst_ctrl #(
  parameter int unsigned DEPTH      = mem_pkg::DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned WIDTH      = mem_pkg::WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  mem_burst_ctrl_if.master      mem
);

  import mem_pkg::*;

  localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

  burst_state_e          state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]      data_q;
  logic                  wr_rd_q;
  logic                  last_word_c;

  // One data register serves both directions: write word to memory, read word to stream.
  assign mem.addr  = addr_q;
  assign mem.wdata = data_q;
  assign mem.wr_rd = wr_rd_q;
  assign rd_data   = data_q;

  assign last_word_c = (rem_q == LEN_WIDTH'(1));

  // Sequencer: every output is a register updated on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      wr_rd_q   <= 1'b0;
      mem.valid <= 1'b0;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            addr_q    <= cmd_addr;
            rem_q     <= cmd_len;
            wr_rd_q   <= cmd_wr;
            if (cmd_len == '0) begin
              state <= FIN;
            end else if (cmd_wr) begin
              state <= WFETCH;
            end else begin
              state     <= RREQ;
              mem.valid <= 1'b1;
            end
          end
        end
        WFETCH: begin
          wr_ready <= 1'b1;
          // wr_ready drops with the consuming edge so a word is never taken twice.
          if (wr_valid && wr_ready) begin
            wr_ready  <= 1'b0;
            data_q    <= wr_data;
            mem.valid <= 1'b1;
            state     <= WREQ;
          end
        end
        WREQ: begin
          if (mem.ready) begin
            mem.valid <= 1'b0;
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            rem_q     <= rem_q - LEN_WIDTH'(1);
            state     <= last_word_c ? FIN : WFETCH;
          end
        end
        RREQ: begin
          if (mem.ready) begin
            mem.valid <= 1'b0;
            data_q    <= mem.rdata;
            rd_valid  <= 1'b1;
            state     <= RHOLD;
          end
        end
        RHOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            rem_q    <= rem_q - LEN_WIDTH'(1);
            if (last_word_c) begin
              state <= FIN;
            end else begin
              state     <= RREQ;
              mem.valid <= 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
